uart_digit_tx: RTL and testbench



---
 rtl/uart_digit_tx_pkg.sv | 39 +++
 rtl/uart_digit_tx_tx_byte.sv | 102 ++++++++++
 rtl/uart_digit_tx.sv | 154 +++++++++++++++
 tb/tb_uart_digit_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_digit_tx_pkg.sv
// Shared types, ASCII constants and the digit-to-ASCII helper for the digit sender.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uart_digit_tx_pkg;

   // Per-byte framing engine states
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Message sequencer states (SEND covers start/data/stop of every byte)
   typedef enum logic [1:0] {
      MSG_IDLE    = 2'd0,
      MSG_SEND    = 2'd1,
      MSG_HOLDOFF = 2'd2
   } msg_state_t;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A_OFF = 8'h37;
   localparam logic [7:0] ASCII_Q     = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // Decimal digits map to '0'..'9'; 10..15 become 'A'..'F' in hex mode, else '?'
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] v, input logic hex);
      logic [7:0] r;
      if (v <= 4'd9)
         r = ASCII_0 + {4'd0, v};
      else if (hex)
         r = ASCII_A_OFF + {4'd0, v};
      else
         r = ASCII_Q;
      return r;
   endfunction

endpackage

// File: rtl/uart_digit_tx_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, one stop bit, DIV clocks per bit.
// Latency: txd drops to the start bit the cycle after an accepted load.
// Backpressure: load only accepted while ready=1; ready rises in the last stop-bit clock for gapless bytes.
module uart_tx_byte
   import uart_digit_tx_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       txd,
   output logic       ready
);

   localparam int             CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   tx_state_t     state_q, state_d;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;
   logic          bit_end;

   assign bit_end = (baud_cnt_q == LAST);
   assign txd     = txd_q;

   // Next-state: advance one bit every DIV clocks, restart framing on an accepted load
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      txd_d      = txd_q;
      ready      = 1'b0;

      if (state_q != TX_IDLE)
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;

      case (state_q)
         TX_IDLE: begin
            ready = 1'b1;
            txd_d = 1'b1;
         end
         TX_START: begin
            if (bit_end) begin
               state_d = TX_DATA;
               txd_d   = shreg_q[0];
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = TX_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shreg_d   = {1'b0, shreg_q[7:1]};
                  txd_d     = shreg_q[1];
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               ready     = 1'b1;
               state_d   = TX_IDLE;
               bit_cnt_d = '0;
            end
         end
         default: state_d = TX_IDLE;
      endcase

      // A load in the final stop clock chains straight into the next start bit
      if (ready && load) begin
         state_d    = TX_START;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
         shreg_d    = data;
         txd_d      = 1'b0;
      end
   end

   // State register; line idles high out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         txd_q      <= txd_d;
      end
   end

endmodule

// File: rtl/uart_digit_tx.sv
// Sends a snapshot of NUM_DIGITS display digits as ASCII over 8N1 UART on a button rising edge.
// Latency: start bit on Txd one clock after the edge; done one clock after the last stop bit.
// Backpressure: edges outside IDLE (sending or hold-off) are dropped, never queued.
module uart_digit_tx
   import uart_digit_tx_pkg::*;
#(
   parameter int CLK_HZ         = 100000000,
   parameter int BAUD           = 9600,
   parameter int NUM_DIGITS     = 4,
   parameter int HEX_MODE       = 0,
   parameter int SEND_CRLF      = 1,
   parameter int MSB_FIRST      = 0,
   parameter int HOLDOFF_CYCLES = 50000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    transmit,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic                    Txd,
   output logic                    busy,
   output logic                    done
);

   localparam int DIV       = CLK_HZ / BAUD;
   localparam int NUM_BYTES = NUM_DIGITS + 2 * SEND_CRLF;
   localparam int BW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(HOLDOFF_CYCLES - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_digit_tx: CLK_HZ/BAUD must be at least 2");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_digits_check
      $error("uart_digit_tx: NUM_DIGITS must be 1..16");
   end

   msg_state_t              state_q, state_d;
   logic                    prev_q, prev_d;
   logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
   logic [BW-1:0]           byte_idx_q, byte_idx_d;
   logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    trigger;
   logic                    tx_load;
   logic                    tx_ready;
   logic [7:0]              tx_data;
   logic [4*NUM_DIGITS-1:0] src_vec;
   logic [BW-1:0]           sel_idx;
   logic [3:0]              nib;
   int                      dsel;

   assign trigger = transmit && !prev_q && (state_q == MSG_IDLE);

   // Byte to load: byte 0 of the live digits on trigger, otherwise the next byte of the snapshot
   always_comb begin
      src_vec = trigger ? digits : snap_q;
      sel_idx = trigger ? '0 : byte_idx_q + 1'b1;
      dsel    = (MSB_FIRST != 0) ? (NUM_DIGITS - 1 - int'(sel_idx)) : int'(sel_idx);
      nib     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dsel == i)
            nib = src_vec[4*i +: 4];
      end
      if (int'(sel_idx) < NUM_DIGITS)
         tx_data = digit_to_ascii(nib, HEX_MODE != 0);
      else if (int'(sel_idx) == NUM_DIGITS)
         tx_data = ASCII_CR;
      else
         tx_data = ASCII_LF;
   end

   // Message sequencer: trigger, chain bytes on ready, hold-off, re-arm
   always_comb begin
      state_d    = state_q;
      prev_d     = transmit;
      snap_d     = snap_q;
      byte_idx_d = byte_idx_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;
      tx_load    = 1'b0;

      case (state_q)
         MSG_IDLE: begin
            if (trigger) begin
               snap_d     = digits;
               byte_idx_d = '0;
               tx_load    = 1'b1;
               state_d    = MSG_SEND;
            end
         end
         MSG_SEND: begin
            if (tx_ready) begin
               if (byte_idx_q == LAST_BYTE) begin
                  byte_idx_d = '0;
                  hold_cnt_d = '0;
                  done_d     = 1'b1;
                  state_d    = (HOLDOFF_CYCLES == 0) ? MSG_IDLE : MSG_HOLDOFF;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  tx_load    = 1'b1;
               end
            end
         end
         MSG_HOLDOFF: begin
            if (hold_cnt_q == LAST_HOLD) begin
               hold_cnt_d = '0;
               state_d    = MSG_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = MSG_IDLE;
      endcase

      busy_d = (state_d != MSG_IDLE);
   end

   // Sequencer registers; prev resets high so a button held through reset is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MSG_IDLE;
         prev_q     <= 1'b1;
         snap_q     <= '0;
         byte_idx_q <= '0;
         hold_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         snap_q     <= snap_d;
         byte_idx_q <= byte_idx_d;
         hold_cnt_q <= hold_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   uart_tx_byte #(.DIV(DIV)) u_tx_byte (
      .clk   (clk),
      .rst   (rst),
      .load  (tx_load),
      .data  (tx_data),
      .txd   (Txd),
      .ready (tx_ready)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_digit_tx.sv
// Bench for uart_digit_tx: three parameter sets, directed plus random digit messages.
// Latency: checks start bit at T+1, done at T+1+msg, busy drop at T+1+msg+holdoff.
// Backpressure: checks ignored edges during send/hold-off and reset abandonment.
module tb_uart_digit_tx;

   localparam int DIV  = 10;
   localparam int HOLD = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        tr_a, tr_b, tr_c;
   logic [15:0] dg_a, dg_b, dg_c;
   logic        txd_a, txd_b, txd_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;

   int n_cmp = 0;
   int n_bad = 0;
   int sel_g = 0;
   logic cur_txd, cur_busy, cur_done;

   always #5 clk = ~clk;

   // defaults: BCD, CR/LF, digit 0 first
   uart_digit_tx #(.CLK_HZ(1000000), .BAUD(100000), .NUM_DIGITS(4), .HEX_MODE(0),
                   .SEND_CRLF(1), .MSB_FIRST(0), .HOLDOFF_CYCLES(HOLD)) u_a (
      .clk(clk), .rst(rst), .transmit(tr_a), .digits(dg_a),
      .Txd(txd_a), .busy(busy_a), .done(done_a));

   // BCD, no CR/LF
   uart_digit_tx #(.CLK_HZ(1000000), .BAUD(100000), .NUM_DIGITS(4), .HEX_MODE(0),
                   .SEND_CRLF(0), .MSB_FIRST(0), .HOLDOFF_CYCLES(HOLD)) u_b (
      .clk(clk), .rst(rst), .transmit(tr_b), .digits(dg_b),
      .Txd(txd_b), .busy(busy_b), .done(done_b));

   // hex, highest digit first, no CR/LF
   uart_digit_tx #(.CLK_HZ(1000000), .BAUD(100000), .NUM_DIGITS(4), .HEX_MODE(1),
                   .SEND_CRLF(0), .MSB_FIRST(1), .HOLDOFF_CYCLES(HOLD)) u_c (
      .clk(clk), .rst(rst), .transmit(tr_c), .digits(dg_c),
      .Txd(txd_c), .busy(busy_c), .done(done_c));

   always_comb begin
      cur_txd  = txd_a;
      cur_busy = busy_a;
      cur_done = done_a;
      case (sel_g)
         1: begin cur_txd = txd_b; cur_busy = busy_b; cur_done = done_b; end
         2: begin cur_txd = txd_c; cur_busy = busy_c; cur_done = done_c; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_tr(input int sel, input logic v);
      case (sel)
         0: tr_a = v;
         1: tr_b = v;
         default: tr_c = v;
      endcase
   endtask

   task automatic set_dg(input int sel, input logic [15:0] v);
      case (sel)
         0: dg_a = v;
         1: dg_b = v;
         default: dg_c = v;
      endcase
   endtask

   // Reference: the ASCII byte at position idx of a message built from digit word d
   function automatic logic [7:0] ref_byte(input logic [15:0] d, input int idx,
                                           input int hex, input int msb);
      int di, v;
      if (idx >= 4)
         return (idx == 4) ? 8'd13 : 8'd10;
      di = msb ? (3 - idx) : idx;
      v  = (int'(d) >> (4 * di)) % 16;
      if (v < 10)  return 8'(48 + v);
      if (hex)     return 8'(55 + v);
      return 8'd63;
   endfunction

   // Quiet line expected for n cycles: Txd high, busy low, no done
   task automatic idle_check(input int sel, input int n, input string tag);
      int bad;
      sel_g = sel;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cur_txd !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) bad++;
      end
      chk({tag, " idle_glitches"}, bad, 0);
   endtask

   // One full message: edge, every bit cell of every byte, done, hold-off, busy fall.
   // Offsets k count from the trigger cycle T; transmit/digits may be poked at given k.
   task automatic run_msg(input int sel, input logic [15:0] d, input int drop_at,
                          input int raise_at, input int chg_at, input logic [15:0] d2,
                          input string tag);
      int hex, msb, crlf, n, k, bad_lvl, bad_ctl;
      logic [7:0] expb, obs;
      logic lvl;
      hex  = (sel == 2) ? 1 : 0;
      msb  = (sel == 2) ? 1 : 0;
      crlf = (sel == 0) ? 1 : 0;
      n    = 4 + 2 * crlf;
      sel_g = sel;
      set_tr(sel, 1'b0);
      set_dg(sel, d);
      @(posedge clk);
      #1 set_tr(sel, 1'b1);
      @(negedge clk);
      chk({tag, " T_txd"}, cur_txd, 1);
      chk({tag, " T_busy"}, cur_busy, 0);
      k = 0;
      for (int f = 0; f < n; f++) begin
         expb = ref_byte(d, f, hex, msb);
         obs = '0;
         bad_lvl = 0;
         bad_ctl = 0;
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < DIV; c++) begin
               @(negedge clk);
               k++;
               lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : expb[b-1];
               if (cur_txd !== lvl) bad_lvl++;
               if (cur_busy !== 1'b1 || cur_done !== 1'b0) bad_ctl++;
               if (c == DIV / 2 && b >= 1 && b <= 8) obs[b-1] = cur_txd;
               if (k == drop_at)  set_tr(sel, 1'b0);
               if (k == raise_at) set_tr(sel, 1'b1);
               if (k == chg_at)   set_dg(sel, d2);
            end
         end
         chk($sformatf("%s byte%0d", tag, f), obs, expb);
         chk($sformatf("%s byte%0d_timing", tag, f), bad_lvl, 0);
         chk($sformatf("%s byte%0d_busy_done", tag, f), bad_ctl, 0);
      end
      @(negedge clk);
      chk($sformatf("%s done_at_T+%0d", tag, k + 1), cur_done, 1);
      chk({tag, " busy_at_done"}, cur_busy, 1);
      bad_ctl = 0;
      for (int i = 2; i <= HOLD; i++) begin
         @(negedge clk);
         if (cur_busy !== 1'b1 || cur_done !== 1'b0 || cur_txd !== 1'b1) bad_ctl++;
      end
      chk({tag, " holdoff"}, bad_ctl, 0);
      @(negedge clk);
      chk($sformatf("%s busy_low_at_T+%0d", tag, k + HOLD + 1), cur_busy, 0);
   endtask

   initial begin
      logic [15:0] rd;
      int rs, bad;

      rst  = 1'b1;
      tr_a = 1'b1;
      tr_b = 1'b0;
      tr_c = 1'b0;
      dg_a = 16'h4321;
      dg_b = '0;
      dg_c = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel_g = s;
         #0;
         chk($sformatf("reset%0d txd", s), cur_txd, 1);
         chk($sformatf("reset%0d busy", s), cur_busy, 0);
         chk($sformatf("reset%0d done", s), cur_done, 0);
      end
      rst = 1'b0;
      // transmit held high across reset must not start a message
      idle_check(0, 20, "held_through_reset");

      // directed messages from fixed digit words
      run_msg(0, 16'h4321, -1, -1, -1, 16'h0, "t1_4321");
      run_msg(1, 16'h00A9, -1, -1, -1, 16'h0, "t2_00A9");
      run_msg(2, 16'hBEEF, -1, -1, -1, 16'h0, "t3_BEEF");

      // level held high: no re-trigger; edge mid-message ignored
      run_msg(0, 16'h8765, -1, -1, -1, 16'h0, "t4_hold");
      idle_check(0, 40, "t4_no_retrigger");
      run_msg(0, 16'h1357, 150, 200, -1, 16'h0, "t4_midedge");
      idle_check(0, 40, "t4_midedge_ignored");
      run_msg(0, 16'h2468, -1, -1, -1, 16'h0, "t4_fresh");

      // digits changing during the message do not disturb the snapshot
      run_msg(0, 16'h4321, -1, -1, 50, 16'h9999, "t5_snapshot");

      // reset at T+250 abandons the frame
      sel_g = 0;
      set_tr(0, 1'b0);
      set_dg(0, 16'h4321);
      @(posedge clk);
      #1 set_tr(0, 1'b1);
      @(negedge clk);
      bad = 0;
      for (int k = 1; k <= 250; k++) begin
         @(negedge clk);
         if (cur_done !== 1'b0) bad++;
      end
      chk("t6 no_done_before_rst", bad, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6 txd_after_rst", cur_txd, 1);
      chk("t6 busy_after_rst", cur_busy, 0);
      rst = 1'b0;
      idle_check(0, 700, "t6_abandoned");
      run_msg(0, 16'h4321, -1, -1, -1, 16'h0, "t6_resend");

      // random digit words on random configurations
      for (int r = 0; r < 5; r++) begin
         rs = $urandom_range(0, 2);
         rd = 16'($urandom);
         run_msg(rs, rd, -1, -1, -1, 16'h0, $sformatf("rand%0d_cfg%0d_%04h", r, rs, rd));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case something never returns to idle
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
